// File: rtl/add_round_key_stage_if.sv
// ----------------------------------------------------------------------------
// add_round_key_stage_if
//   Bundles the stream and key-load signals of the AddRoundKey stage.
//   Bytes within a state are indexed 0..15. Byte 0 is the most significant
//   byte, so a state can also be handled as one 128-bit vector.
//
//   Upstream stream   : in_valid, in_ready, in_round, data_in
//   Key store write   : key_we, key_addr, key_wdata
//   Downstream stream : out_valid, out_ready, out_round, out_err, data_out
//
//   Modports
//     slave  : the stage's view (consumes upstream, drives downstream)
//     master : the environment's view
// ----------------------------------------------------------------------------
interface add_round_key_stage_if #(
    parameter int RIDX_W = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [RIDX_W-1:0]       in_round;
    logic [0:15][7:0]        data_in;

    logic                    key_we;
    logic [RIDX_W-1:0]       key_addr;
    logic [127:0]            key_wdata;

    logic                    out_valid;
    logic                    out_ready;
    logic [RIDX_W-1:0]       out_round;
    logic                    out_err;
    logic [0:15][7:0]        data_out;

    modport slave (
        input  in_valid, in_round, data_in,
        input  key_we, key_addr, key_wdata,
        input  out_ready,
        output in_ready,
        output out_valid, out_round, out_err, data_out
    );

    modport master (
        output in_valid, in_round, data_in,
        output key_we, key_addr, key_wdata,
        output out_ready,
        input  in_ready,
        input  out_valid, out_round, out_err, data_out
    );
endinterface

// File: rtl/add_round_key_stage.sv
// ----------------------------------------------------------------------------
// add_round_key_stage
//   Registered AddRoundKey stage of the iterative AES-128 datapath. It sits
//   after MixColumns. Each accepted state is XORed with the round key that
//   its round index selects. Keys live in an internal (NR+1)-entry store that
//   the key-expansion engine loads. A one-entry skid buffer keeps the stage
//   at one state per cycle under backpressure. in_ready is a register, so
//   there is no combinational path from out_ready to in_ready.
//
//   Ports
//     clk      : clock
//     rst_n    : asynchronous active-low reset. Clears the pipeline and the
//                key store.
//     zeroize  : (ARK_ZEROIZE_EN only) clears the key store and drops any
//                pending beats
//     bus      : add_round_key_stage_if.slave carrying the upstream stream,
//                the key writes and the downstream stream
//
//   Build option
//     ARK_ZEROIZE_EN : when defined, adds the zeroize port and its logic.
//
//   Occupancy (out_valid, skid_valid)
//     state     | meaning
//     ----------+--------------------------------------------------------
//     EMPTY 0,0 | nothing held; in_ready=1
//     ONE   1,0 | output register holds a beat; in_ready=1
//     FULL  1,1 | output and skid both hold beats; in_ready=0
// ----------------------------------------------------------------------------
module add_round_key_stage #(
    parameter int NR     = 10,
    parameter int RIDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef ARK_ZEROIZE_EN
    input  logic                 zeroize,
`endif
    add_round_key_stage_if.slave bus
);

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NR);

    logic [127:0]      r_key [0:NR];

    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_out_err;
    logic [RIDX_W-1:0] r_out_round;
    logic [127:0]      r_out_data;

    logic              r_skid_valid;
    logic              r_skid_err;
    logic [RIDX_W-1:0] r_skid_round;
    logic [127:0]      r_skid_data;

    logic              w_zeroize;
    logic              w_in_ready;
    logic              w_acc;
    logic              w_out_free;
    logic              w_skid_next;
    logic              w_in_range;
    logic              w_key_fwd;
    logic [127:0]      w_key_sel;
    logic [127:0]      w_result;

`ifdef ARK_ZEROIZE_EN
    assign w_zeroize = zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    // A zeroize cycle must not accept a beat, because that beat would
    // survive the flush.
    assign w_in_ready = r_in_ready && !w_zeroize;
    assign w_acc      = bus.in_valid && w_in_ready;

    // The output register can take a beat this cycle if it is empty or
    // if it is being drained.
    assign w_out_free = !r_out_valid || bus.out_ready;

    assign w_in_range = (bus.in_round <= LAST_IDX);
    assign w_key_fwd  = bus.key_we && (bus.key_addr == bus.in_round);

    // An out-of-range round uses a zero key, so the data passes through
    // unchanged. A key written in the same cycle as the accept is
    // forwarded, so the beat sees the new key.
    always_comb begin
        w_key_sel = '0;
        if (w_in_range) begin
            w_key_sel = w_key_fwd ? bus.key_wdata : r_key[bus.in_round];
        end
    end

    assign w_result = bus.data_in ^ w_key_sel;

    // An accept can only occur while the skid buffer is empty, so the skid
    // buffer is loaded only when an accepted beat meets a stalled output.
    assign w_skid_next = r_skid_valid ? !w_out_free : (w_acc && !w_out_free);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                r_key[i] <= '0;
            end
        end else if (w_zeroize) begin
            for (int i = 0; i <= NR; i++) begin
                r_key[i] <= '0;
            end
        end else if (bus.key_we && (bus.key_addr <= LAST_IDX)) begin
            r_key[bus.key_addr] <= bus.key_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_err    <= 1'b0;
            r_out_round  <= '0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_err   <= 1'b0;
            r_skid_round <= '0;
            r_skid_data  <= '0;
        end else if (w_zeroize) begin
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_out_free) begin
                // The skid entry is older than any new beat, so it goes out first.
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_err   <= r_skid_err;
                    r_out_round <= r_skid_round;
                    r_out_data  <= r_skid_data;
                end else if (w_acc) begin
                    r_out_valid <= 1'b1;
                    r_out_err   <= !w_in_range;
                    r_out_round <= bus.in_round;
                    r_out_data  <= w_result;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end

            if (w_acc && !w_out_free) begin
                r_skid_err   <= !w_in_range;
                r_skid_round <= bus.in_round;
                r_skid_data  <= w_result;
            end

            r_skid_valid <= w_skid_next;
            r_in_ready   <= !w_skid_next;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_err   = r_out_err;
    assign bus.out_round = r_out_round;
    assign bus.data_out  = r_out_data;

endmodule

// File: tb/tb_add_round_key_stage.sv
// ----------------------------------------------------------------------------
// tb_add_round_key_stage
//   Self-checking bench for add_round_key_stage. A reference model keeps a
//   copy of the key store and a queue of expected output beats. Each beat is
//   computed at accept time from the stage's rules. Directed scenarios come
//   first, then randomized traffic.
// ----------------------------------------------------------------------------
module tb_add_round_key_stage;

    localparam int NR = 10;
    localparam int RW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic zeroize = 1'b0;

    always #5 clk = ~clk;

    add_round_key_stage_if #(.RIDX_W(RW)) bus ();

    add_round_key_stage #(.NR(NR), .RIDX_W(RW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef ARK_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .bus     (bus)
    );

    typedef struct {
        logic [127:0]   data;
        logic [RW-1:0]  round;
        logic           err;
    } beat_t;

    logic [127:0] mkey [0:NR];
    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t ref_q[$];
    int    unexp;
    logic  last_acc;

    int errors = 0;
    int checks = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_round  = '0;
        bus.data_in   = '0;
        bus.key_we    = 1'b0;
        bus.key_addr  = '0;
        bus.key_wdata = '0;
        bus.out_ready = 1'b1;
        zeroize       = 1'b0;
    endtask

    task automatic clear_logs();
        obs_q.delete();
        ref_q.delete();
        unexp = 0;
    endtask

    // One clock of activity. The inputs are already driven. The task samples
    // just after the falling edge and advances the model at the rising edge.
    task automatic tick();
        logic         acc, fire, zact;
        beat_t        nb, ob;
        logic [127:0] k;
        nb = '{default: '0};
        #1;
        acc  = bus.in_valid && bus.in_ready;
        fire = bus.out_valid && bus.out_ready;
`ifdef ARK_ZEROIZE_EN
        zact = zeroize;
`else
        zact = 1'b0;
`endif
        if (fire) begin
            ob.data  = bus.data_out;
            ob.round = bus.out_round;
            ob.err   = bus.out_err;
            obs_q.push_back(ob);
            if (exp_q.size() > 0) ref_q.push_back(exp_q.pop_front());
            else unexp++;
        end
        if (acc) begin
            nb.round = bus.in_round;
            if (int'(bus.in_round) > NR) begin
                nb.data = bus.data_in;
                nb.err  = 1'b1;
            end else begin
                k = (bus.key_we && bus.key_addr == bus.in_round) ? bus.key_wdata
                                                                : mkey[bus.in_round];
                nb.data = bus.data_in ^ k;
                nb.err  = 1'b0;
            end
        end
        last_acc = acc;
        @(posedge clk);
        if (zact) begin
            for (int i = 0; i <= NR; i++) mkey[i] = '0;
            exp_q.delete();
        end else begin
            if (bus.key_we && int'(bus.key_addr) <= NR) mkey[bus.key_addr] = bus.key_wdata;
            if (acc) exp_q.push_back(nb);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    endtask

    task automatic write_key(input int addr, input logic [127:0] val);
        idle();
        bus.key_we    = 1'b1;
        bus.key_addr  = RW'(addr);
        bus.key_wdata = val;
        tick();
        idle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        for (int i = 0; i <= NR; i++) mkey[i] = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b exp=0", bus.out_err); end
        checks++; if (bus.out_round !== '0) begin errors++; $display("FAIL reset_out_round got=%0d exp=0", bus.out_round); end
        checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", bus.data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips();
        clear_logs();
        write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
        bus.in_valid = 1'b1;
        bus.in_round = '0;
        bus.data_in  = 128'h00112233445566778899aabbccddeeff;
        tick();
        idle();
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fips_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.data_out !== 128'h00102030405060708090a0b0c0d0e0f0) begin errors++; $display("FAIL fips_data got=%h exp=00102030405060708090a0b0c0d0e0f0", bus.data_out); end
        checks++; if (bus.out_round !== '0) begin errors++; $display("FAIL fips_round got=%0d exp=0", bus.out_round); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL fips_err got=%b exp=0", bus.out_err); end
        drain();
        checks++; if (obs_q.size() != 1 || unexp != 0) begin errors++; $display("FAIL fips_count got=%0d exp=1", obs_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [127:0] din [0:3];
        int b;
        int cyc;
        for (int i = 1; i <= 4; i++) write_key(i, rand128());
        for (int i = 0; i < 4; i++) din[i] = rand128();
        clear_logs();
        b = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = (b < 4);
            bus.in_round = RW'(b + 1);
            bus.data_in  = din[b % 4];
            tick();
            if (last_acc) b++;
            if (c > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.data_out !== exp_q[0].data || bus.out_round !== RW'(1)) begin
                    errors++;
                    $display("FAIL bp_hold cycle=%0d got=%h/%0d exp=%h/1", c, bus.data_out, bus.out_round, exp_q[0].data);
                end
            end
        end
        checks++; if (b != 2) begin errors++; $display("FAIL bp_accepts got=%0d exp=2", b); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
        bus.out_ready = 1'b1;
        cyc = 0;
        while (b < 4 && cyc < 20) begin
            bus.in_valid = 1'b1;
            bus.in_round = RW'(b + 1);
            bus.data_in  = din[b];
            tick();
            if (last_acc) b++;
            cyc++;
        end
        drain();
        checks++; if (obs_q.size() != 4 || unexp != 0 || exp_q.size() != 0) begin errors++; $display("FAIL bp_count got=%0d exp=4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++) begin
            checks++;
            if (obs_q[i].data !== ref_q[i].data || obs_q[i].round !== RW'(i + 1) || obs_q[i].err !== 1'b0) begin
                errors++;
                $display("FAIL bp_beat%0d got=%h/%0d exp=%h/%0d", i, obs_q[i].data, obs_q[i].round, ref_q[i].data, i + 1);
            end
        end
    endtask

    task automatic test_collision();
        write_key(3, 128'h0123456789abcdef0123456789abcdef);
        clear_logs();
        bus.key_we    = 1'b1;
        bus.key_addr  = RW'(3);
        bus.key_wdata = {128{1'b1}};
        bus.in_valid  = 1'b1;
        bus.in_round  = RW'(3);
        bus.data_in   = '0;
        tick();
        drain();
        checks++;
        if (obs_q.size() != 1 || obs_q[0].data !== {128{1'b1}}) begin
            errors++;
            $display("FAIL collision got=%h exp=all ones (n=%0d)", (obs_q.size() > 0) ? obs_q[0].data : 128'h0, obs_q.size());
        end
    endtask

    task automatic test_out_of_range();
        logic [127:0] d2;
        logic [127:0] saved [0:NR];
        d2 = rand128();
        clear_logs();
        bus.in_valid = 1'b1;
        bus.in_round = RW'(11);
        bus.data_in  = 128'h0123456789abcdeffedcba9876543210;
        tick();
        bus.in_round = RW'(2);
        bus.data_in  = d2;
        tick();
        drain();
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL oor_count got=%0d exp=2", obs_q.size());
        end else begin
            checks++; if (obs_q[0].data !== 128'h0123456789abcdeffedcba9876543210 || obs_q[0].err !== 1'b1)
                begin errors++; $display("FAIL oor_beat got=%h err=%b exp=0123456789abcdeffedcba9876543210 err=1", obs_q[0].data, obs_q[0].err); end
            checks++; if (obs_q[1].err !== 1'b0 || obs_q[1].data !== ref_q[1].data)
                begin errors++; $display("FAIL oor_next got=%h err=%b exp=%h err=0", obs_q[1].data, obs_q[1].err, ref_q[1].data); end
        end
        for (int i = 0; i <= NR; i++) saved[i] = mkey[i];
        write_key(12, rand128());
        clear_logs();
        for (int i = 0; i <= NR; i++) begin
            bus.in_valid = 1'b1;
            bus.in_round = RW'(i);
            bus.data_in  = '0;
            tick();
        end
        drain();
        checks++; if (obs_q.size() != NR + 1) begin errors++; $display("FAIL oor_keyscan_count got=%0d exp=%0d", obs_q.size(), NR + 1); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].data !== saved[int'(obs_q[i].round)]) begin
                errors++; $display("FAIL oor_key%0d got=%h exp=%h", obs_q[i].round, obs_q[i].data, saved[int'(obs_q[i].round)]);
            end
        end
    endtask

    task automatic test_random();
        clear_logs();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_round  = RW'($urandom_range(15));
            bus.data_in   = rand128();
            bus.key_we    = ($urandom_range(3) == 0);
            bus.key_addr  = RW'($urandom_range(15));
            bus.key_wdata = rand128();
            bus.out_ready = ($urandom_range(2) != 0);
            tick();
        end
        drain();
        checks++; if (unexp != 0 || exp_q.size() != 0 || obs_q.size() != ref_q.size())
            begin errors++; $display("FAIL rand_count got=%0d exp=%0d unexpected=%0d", obs_q.size(), ref_q.size(), unexp); end
        for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++) begin
            checks++;
            if (obs_q[i].data !== ref_q[i].data || obs_q[i].round !== ref_q[i].round || obs_q[i].err !== ref_q[i].err) begin
                errors++;
                $display("FAIL rand_beat%0d got=%h/%0d/%b exp=%h/%0d/%b", i, obs_q[i].data, obs_q[i].round, obs_q[i].err,
                         ref_q[i].data, ref_q[i].round, ref_q[i].err);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        write_key(0, rand128());
        clear_logs();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_round  = RW'(0);
        bus.data_in   = rand128();
        tick();
        bus.data_in   = rand128();
        tick();
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
            begin errors++; $display("FAIL rstmid_full got in_ready=%b out_valid=%b exp 0/1", bus.in_ready, bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
        for (int i = 0; i <= NR; i++) mkey[i] = '0;
        exp_q.delete();
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        d = rand128();
        bus.in_valid = 1'b1;
        bus.in_round = RW'(0);
        bus.data_in  = d;
        tick();
        drain();
        checks++; if (obs_q.size() != 1 || obs_q[0].data !== d)
            begin errors++; $display("FAIL rstmid_zero_key got=%h exp=%h (n=%0d)", (obs_q.size() > 0) ? obs_q[0].data : 128'h0, d, obs_q.size()); end
    endtask

`ifdef ARK_ZEROIZE_EN
    task automatic test_zeroize();
        logic [127:0] d;
        write_key(5, rand128());
        clear_logs();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_round  = RW'(5);
        bus.data_in   = rand128();
        tick();
        zeroize       = 1'b1;
        bus.key_we    = 1'b1;
        bus.key_addr  = RW'(5);
        bus.key_wdata = rand128();
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        idle();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid got=%b exp=0", bus.out_valid); end
        d = rand128();
        bus.in_valid = 1'b1;
        bus.in_round = RW'(5);
        bus.data_in  = d;
        tick();
        drain();
        checks++; if (obs_q.size() != 1 || obs_q[0].data !== d)
            begin errors++; $display("FAIL zero_pass got=%h exp=%h (n=%0d)", (obs_q.size() > 0) ? obs_q[0].data : 128'h0, d, obs_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_fips();
        test_backpressure();
        test_collision();
        test_out_of_range();
        test_random();
        test_reset_mid();
`ifdef ARK_ZEROIZE_EN
        test_zeroize();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
